vga_sync_decoder: RTL

Receive-side counterpart of the VGA sync timer: samples an incoming hsync/vsync/activevideo triple on the pixel-tick enable and recovers the generator's x/y coordinates. Measures line length and lines-per-frame, and runs a lock state machine against the nominal 640x480 mode. Sits on the capture/loopback path, feeding recovered coordinates to downstream pixel logic and a lock status to the top level.

---
 rtl/vga_sync_decoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers x/y coordinates from a sampled hsync/vsync/activevideo stream,
// measures line and frame lengths, and tracks lock against the nominal mode.
module vga_sync_decoder #(
   parameter int WHOLE_LINE   = 800,
   parameter int WHOLE_FRAME  = 525,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480,
   parameter int H_SYNC_START = 656,
   parameter int V_SYNC_START = 490,
   parameter int XBITS        = 10,
   parameter int YBITS        = 10,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pixtick,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             activevideo,
   output logic [XBITS-1:0] x,
   output logic [YBITS-1:0] y,
   output logic             locked,
   output logic [XBITS-1:0] line_len,
   output logic [YBITS-1:0] frame_lines,
   output logic             lost,
   output logic             de_err
);

   localparam int LCW = XBITS + 1;
   localparam int MW  = $clog2(LOCK_FRAMES + 1);

   localparam logic [XBITS-1:0] X_LAST = XBITS'(WHOLE_LINE - 1);
   localparam logic [XBITS-1:0] X_SYNC = XBITS'(H_SYNC_START);
   localparam logic [XBITS-1:0] X_VIS  = XBITS'(H_VISIBLE);
   localparam logic [YBITS-1:0] Y_LAST = YBITS'(WHOLE_FRAME - 1);
   localparam logic [YBITS-1:0] Y_SYNC = YBITS'(V_SYNC_START);
   localparam logic [YBITS-1:0] Y_VIS  = YBITS'(V_VISIBLE);
   localparam logic [YBITS-1:0] Y_FULL = YBITS'(WHOLE_FRAME);
   localparam logic [LCW-1:0]   L_FULL = LCW'(WHOLE_LINE);
   localparam logic [LCW-1:0]   L_TMO  = LCW'(2 * WHOLE_LINE);
   localparam logic [LCW-1:0]   L_SAT  = '1;
   localparam logic [MW-1:0]    M_LOCK = MW'(LOCK_FRAMES);

   typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

   state_t           state_q, state_d;
   logic             hs_q, hs_d, vs_q, vs_d;
   logic [XBITS-1:0] x_q, x_d, line_len_q, line_len_d;
   logic [YBITS-1:0] y_q, y_d, frame_lines_q, frame_lines_d;
   logic [YBITS-1:0] line_edges_q, line_edges_d, edges_close;
   logic [LCW-1:0]   line_cnt_q, line_cnt_d;
   logic [MW-1:0]    match_q, match_d;
   logic             bad_frame_q, bad_frame_d;
   logic             lost_q, lost_d, de_err_q, de_err_d;
   logic             hfall, vfall, x_wrap, line_bad, good_frame, timeout;

   assign hfall = pixtick & hs_q & ~hsync;
   assign vfall = pixtick & vs_q & ~vsync;

   always_comb begin
      hs_d          = hs_q;
      vs_d          = vs_q;
      x_d           = x_q;
      y_d           = y_q;
      line_cnt_d    = line_cnt_q;
      line_len_d    = line_len_q;
      line_edges_d  = line_edges_q;
      frame_lines_d = frame_lines_q;
      bad_frame_d   = bad_frame_q;
      match_d       = match_q;
      state_d       = state_q;
      lost_d        = 1'b0;
      de_err_d      = 1'b0;
      x_wrap        = 1'b0;
      line_bad      = 1'b0;
      timeout       = 1'b0;
      edges_close   = line_edges_q + (hfall ? YBITS'(1) : YBITS'(0));
      good_frame    = 1'b0;

      if (pixtick) begin
         hs_d = hsync;
         vs_d = vsync;

         x_wrap = ~hfall & (x_q == X_LAST);
         if (hfall)       x_d = X_SYNC;
         else if (x_wrap) x_d = '0;
         else             x_d = x_q + XBITS'(1);

         if (vfall)       y_d = Y_SYNC;
         else if (x_wrap) y_d = (y_q == Y_LAST) ? '0 : y_q + YBITS'(1);

         line_bad = hfall & (line_cnt_q != L_FULL);
         if (hfall) begin
            line_len_d = line_cnt_q[XBITS-1:0];
            line_cnt_d = LCW'(1);
         end else if (line_cnt_q != L_SAT) begin
            line_cnt_d = line_cnt_q + LCW'(1);
            timeout    = (line_cnt_d == L_TMO);
         end

         // A bad line coinciding with vfall still belongs to the closing frame.
         good_frame = ~(bad_frame_q | line_bad) & (edges_close == Y_FULL);
         if (vfall) begin
            frame_lines_d = edges_close;
            line_edges_d  = '0;
            bad_frame_d   = 1'b0;
         end else begin
            if (hfall)    line_edges_d = line_edges_q + YBITS'(1);
            if (line_bad) bad_frame_d  = 1'b1;
         end

         // activevideo is paired with the pixel position it is registered against.
         if (state_q == ST_LOCKED &&
             (activevideo != ((x_d < X_VIS) && (y_d < Y_VIS))))
            de_err_d = 1'b1;
      end

      case (state_q)
         ST_SEARCH: begin
            if (vfall) begin
               state_d = ST_ACQUIRE;
               match_d = '0;
            end
         end
         ST_ACQUIRE: begin
            if (vfall) begin
               if (good_frame) begin
                  match_d = match_q + MW'(1);
                  if (match_d == M_LOCK) state_d = ST_LOCKED;
               end else begin
                  match_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (line_bad || (vfall && !good_frame)) begin
               state_d = ST_SEARCH;
               lost_d  = 1'b1;
            end
         end
         default: state_d = ST_SEARCH;
      endcase

      if (timeout) begin
         state_d = ST_SEARCH;
         lost_d  = (state_q == ST_LOCKED);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_SEARCH;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         line_cnt_q    <= '0;
         line_len_q    <= '0;
         line_edges_q  <= '0;
         frame_lines_q <= '0;
         bad_frame_q   <= 1'b0;
         match_q       <= '0;
         lost_q        <= 1'b0;
         de_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_cnt_q    <= line_cnt_d;
         line_len_q    <= line_len_d;
         line_edges_q  <= line_edges_d;
         frame_lines_q <= frame_lines_d;
         bad_frame_q   <= bad_frame_d;
         match_q       <= match_d;
         lost_q        <= lost_d;
         de_err_q      <= de_err_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign locked      = (state_q == ST_LOCKED);
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign lost        = lost_q;
   assign de_err      = de_err_q;

endmodule
